// File: rtl/spsram_arbiter.sv
// spsram_arbiter: two-requester round-robin/lock arbiter in front of one single-port synchronous-read SRAM.
// Define SPSRAM_ARB_FIXED_PRIO_EN to make A always win IDLE ties (no rotating pointer).
module spsram_arbiter #(
   parameter int BW_DATA = 32,
   parameter int BW_ADDR = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_a_req,
   input  logic               i_a_lock,
   input  logic               i_a_wen,
   input  logic [BW_ADDR-1:0] i_a_addr,
   input  logic [BW_DATA-1:0] i_a_wdata,
   output logic               o_a_gnt,
   output logic               o_a_rvalid,
   input  logic               i_b_req,
   input  logic               i_b_lock,
   input  logic               i_b_wen,
   input  logic [BW_ADDR-1:0] i_b_addr,
   input  logic [BW_DATA-1:0] i_b_wdata,
   output logic               o_b_gnt,
   output logic               o_b_rvalid,
   output logic [BW_DATA-1:0] o_rdata,
   output logic               o_mem_cen,
   output logic               o_mem_wen,
   output logic               o_mem_oen,
   output logic [BW_ADDR-1:0] o_mem_addr,
   output logic [BW_DATA-1:0] o_mem_data,
   input  logic [BW_DATA-1:0] i_mem_data
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;
   logic [1:0] state_q, state_d;
   logic       a_rv_q, a_rv_d, b_rv_q, b_rv_d;
   logic       locked_a, locked_b, free, pick_a;
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
   logic       ptr_q, ptr_d, turn;
`endif
   always_comb begin
      locked_a = (state_q == OWN_A) && i_a_req;
      locked_b = (state_q == OWN_B) && i_b_req;
      free     = !locked_a && !locked_b;
`ifdef SPSRAM_ARB_FIXED_PRIO_EN
      pick_a   = i_a_req;
`else
      // a lock released this cycle already hands the turn to the other side
      turn     = ((state_q == OWN_A) && !i_a_req) ? 1'b1 :
                 ((state_q == OWN_B) && !i_b_req) ? 1'b0 : ptr_q;
      pick_a   = i_a_req && (!i_b_req || !turn);
`endif
      o_a_gnt  = !i_rst && (locked_a || (free && pick_a));
      o_b_gnt  = !i_rst && (locked_b || (free && i_b_req && !pick_a));
      state_d  = (o_a_gnt && i_a_lock) ? OWN_A : (o_b_gnt && i_b_lock) ? OWN_B : IDLE;
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
      ptr_d    = (o_a_gnt && !i_a_lock) ? 1'b1 : (o_b_gnt && !i_b_lock) ? 1'b0 : turn;
`endif
      a_rv_d   = o_a_gnt && !i_a_wen;
      b_rv_d   = o_b_gnt && !i_b_wen;
   end
   assign o_mem_cen  = o_a_gnt || o_b_gnt;
   assign o_mem_oen  = 1'b1;
   assign o_mem_wen  = o_a_gnt ? i_a_wen   : (o_b_gnt && i_b_wen);
   assign o_mem_addr = o_a_gnt ? i_a_addr  : o_b_gnt ? i_b_addr  : '0;
   assign o_mem_data = o_a_gnt ? i_a_wdata : o_b_gnt ? i_b_wdata : '0;
   assign o_rdata    = i_mem_data;
   // a read granted just before reset must not surface while reset is held
   assign o_a_rvalid = a_rv_q && !i_rst;
   assign o_b_rvalid = b_rv_q && !i_rst;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         a_rv_q  <= 1'b0;
         b_rv_q  <= 1'b0;
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
         ptr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_rv_q  <= a_rv_d;
         b_rv_q  <= b_rv_d;
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end
endmodule

// File: tb/tb_spsram_arbiter.sv
// tb_spsram_arbiter: randomized and directed checks of spsram_arbiter against an owner/turn reference model.
module tb_spsram_arbiter;
   localparam int BD = 32;
   localparam int BA = 5;
   logic          clk = 1'b0, rst = 1'b1;
   logic          a_req, a_lock, a_wen, b_req, b_lock, b_wen;
   logic [BA-1:0] a_addr, b_addr;
   logic [BD-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [BD-1:0] rdata, mem_wdata, mem_q;
   logic          mem_cen, mem_wen, mem_oen;
   logic [BA-1:0] mem_addr;
   logic [BD-1:0] mem [32];
   logic [BD-1:0] ref_mem [32];
   int            owner;
   bit            ptr, rv_a, rv_b;
   logic [BD-1:0] rd_exp, e_rdata, s_rdata;
   logic [43:0]   obs, exp_v;
   bit            e_ga, e_gb;
   int            n_checks = 0, n_fail = 0;

   spsram_arbiter #(.BW_DATA(BD), .BW_ADDR(BA)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_a_req(a_req), .i_a_lock(a_lock), .i_a_wen(a_wen), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
      .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid),
      .i_b_req(b_req), .i_b_lock(b_lock), .i_b_wen(b_wen), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
      .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid),
      .o_rdata(rdata), .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_oen(mem_oen),
      .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .i_mem_data(mem_q)
   );

   always #5 clk = ~clk;

   // synchronous-read SRAM; reloaded from the reference image while reset is held
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
      end else if (mem_cen) begin
         if (mem_wen) mem[mem_addr] <= mem_wdata;
         else mem_q <= mem[mem_addr];
      end
   end

   task automatic tick();
      bit ga, gb, turn, wen;
      logic [BA-1:0] ad;
      logic [BD-1:0] wd;
      @(negedge clk);
      obs = {a_gnt, b_gnt, mem_cen, mem_oen, mem_wen, mem_addr, mem_wdata, a_rvalid, b_rvalid};
      s_rdata = rdata;
      turn = (owner == 1 && !a_req) ? 1'b1 : (owner == 2 && !b_req) ? 1'b0 : ptr;
`ifdef SPSRAM_ARB_FIXED_PRIO_EN
      turn = 1'b0;
`endif
      ga = 1'b0;
      gb = 1'b0;
      if (rst) ga = 1'b0;
      else if (owner == 1 && a_req) ga = 1'b1;
      else if (owner == 2 && b_req) gb = 1'b1;
      else if (a_req && b_req) begin ga = !turn; gb = turn; end
      else begin ga = a_req; gb = b_req; end
      ad = ga ? a_addr : gb ? b_addr : '0;
      wd = ga ? a_wdata : gb ? b_wdata : '0;
      wen = ga ? a_wen : (gb && b_wen);
      e_ga = ga;
      e_gb = gb;
      exp_v = {ga, gb, ga | gb, 1'b1, wen, ad, wd, rv_a && !rst, rv_b && !rst};
      e_rdata = rd_exp;
      @(posedge clk);
      if (rst) begin
         owner = 0; ptr = 1'b0; rv_a = 1'b0; rv_b = 1'b0;
      end else begin
         rv_a = ga && !a_wen;
         rv_b = gb && !b_wen;
         if ((ga || gb) && !wen) rd_exp = ref_mem[ad];
         if ((ga || gb) && wen) ref_mem[ad] = wd;
         owner = (ga && a_lock) ? 1 : (gb && b_lock) ? 2 : 0;
         ptr = (ga && !a_lock) ? 1'b1 : (gb && !b_lock) ? 1'b0 : turn;
      end
      #1;
   endtask

   task automatic test_reset();
      a_req = 1'b1; b_req = 1'b1; a_wen = 1'b0; b_wen = 1'b0; rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
      end
      rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[1:0] !== 2'b00) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_single_read();
      a_req = 1'b1; a_wen = 1'b0; a_lock = 1'b0; a_addr = 5'd3;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[43] !== 1'b1) begin n_fail++; $display("FAIL read3_gnt: got %h want %h", obs, exp_v); end
      a_req = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_v || s_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read3_data: got %h/%h want %h/deadbeef", obs, s_rdata, exp_v); end
   endtask

   task automatic test_write_read();
      a_req = 1'b1; a_wen = 1'b1; a_addr = 5'd5; a_wdata = 32'h1234;
      tick();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL wr5_gnt: got %h want %h", obs, exp_v); end
      a_req = 1'b0; b_req = 1'b1; b_wen = 1'b0; b_lock = 1'b0; b_addr = 5'd5;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[42] !== 1'b1) begin n_fail++; $display("FAIL rd5_gnt: got %h want %h", obs, exp_v); end
      b_req = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[0] !== 1'b1 || s_rdata !== 32'h1234) begin n_fail++; $display("FAIL rd5_data: got %h/%h want %h/00001234", obs, s_rdata, exp_v); end
   endtask

   task automatic test_round_robin();
      bit prev;
      a_req = 1'b1; b_req = 1'b1; a_lock = 1'b0; b_lock = 1'b0; a_wen = 1'b0; b_wen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         a_addr = BA'($urandom); b_addr = BA'($urandom);
         tick();
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL rr_model[%0d]: got %h want %h", k, obs, exp_v); end
         if (obs[1] && s_rdata !== e_rdata) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, s_rdata, e_rdata); end
`ifdef SPSRAM_ARB_FIXED_PRIO_EN
         n_checks++;
         if (obs[43] !== 1'b1) begin n_fail++; $display("FAIL fixed_prio[%0d]: a_gnt %b want 1", k, obs[43]); end
`else
         if (k > 0) begin
            n_checks++;
            if (obs[43] !== !prev) begin n_fail++; $display("FAIL rr_alternate[%0d]: a_gnt %b want %b", k, obs[43], !prev); end
         end
`endif
         prev = obs[43];
      end
      a_req = 1'b0; b_req = 1'b0;
      tick();
   endtask

   task automatic test_lock();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_req = 1'b1; a_lock = 1'b1; a_wen = 1'b0;
      b_req = 1'b1; b_lock = 1'b0; b_wen = 1'b0; b_addr = 5'd7;
      for (int k = 0; k < 4; k++) begin
         a_addr = BA'(k);
         tick();
         n_checks++;
         if (obs !== exp_v || obs[43] !== 1'b1) begin n_fail++; $display("FAIL lock_burst[%0d]: got %h want %h", k, obs, exp_v); end
      end
      a_req = 1'b0; a_lock = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[42] !== 1'b1) begin n_fail++; $display("FAIL lock_handover: got %h want %h", obs, exp_v); end
      b_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      a_req = 1'b1; a_wen = 1'b0; a_lock = 1'b0; a_addr = 5'd9;
      tick();
      a_req = 1'b0; rst = 1'b1;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[1] !== 1'b0) begin n_fail++; $display("FAIL rst_drop_rvalid: got %h want %h", obs, exp_v); end
      rst = 1'b0; a_req = 1'b1; b_req = 1'b1; b_wen = 1'b0; b_lock = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_v || obs[43] !== 1'b1 || obs[1] !== 1'b0) begin n_fail++; $display("FAIL rst_tie_a: got %h want %h", obs, exp_v); end
      a_req = 1'b0; b_req = 1'b0;
      tick();
   endtask

   task automatic test_idle();
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (obs !== exp_v || obs[41] !== 1'b0 || obs[1:0] !== 2'b00) begin n_fail++; $display("FAIL idle[%0d]: got %h want %h", k, obs, exp_v); end
      end
      for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL idle_mem: %0d words differ, want 0", bad); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         tick();
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL rand_model[%0d]: got %h want %h", k, obs, exp_v); end
         if (obs[1:0] != 2'b00 && s_rdata !== e_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, s_rdata, e_rdata); end
         if (e_ga || !a_req || $urandom_range(15) == 0) begin
            a_req = ($urandom_range(2) != 0); a_lock = ($urandom_range(2) == 0); a_wen = $urandom_range(1) != 0;
            a_addr = BA'($urandom); a_wdata = $urandom;
         end
         if (e_gb || !b_req || $urandom_range(15) == 0) begin
            b_req = ($urandom_range(2) != 0); b_lock = ($urandom_range(2) == 0); b_wen = $urandom_range(1) != 0;
            b_addr = BA'($urandom); b_wdata = $urandom;
         end
      end
      a_req = 1'b0; b_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
      ref_mem[3] = 32'hDEADBEEF;
      owner = 0; ptr = 1'b0; rv_a = 1'b0; rv_b = 1'b0; rd_exp = '0;
      a_req = 1'b0; a_lock = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_lock = 1'b0; b_wen = 1'b0; b_addr = '0; b_wdata = '0;
      test_reset();
      test_single_read();
      test_write_read();
      test_round_robin();
      test_lock();
      test_reset_mid();
      test_idle();
      test_random();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
